upcoin_nonce_scheduler: RTL and testbench

Mining sequencer that drives a single-block SHA-256 compression core through the uPcoin double-hash flow: header block 1 once (midstate), then for each nonce header block 2 chained from the midstate, then a second SHA-256 of the 256-bit digest. Each final digest is compared against a target. The block stops on the first hit, on range exhaustion, or on abort. It sits between the SPI/host register layer and the compression core.

---
 rtl/upcoin_nonce_scheduler.sv | 126 ++++++++++++
 tb/tb_upcoin_nonce_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/upcoin_nonce_scheduler.sv
// upcoin_nonce_scheduler: sequences midstate, per-nonce block-2 and second SHA-256 passes on a compression core and compares digests against a target
module upcoin_nonce_scheduler #(
  parameter logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] header_lo,
  input  logic [95:0]  header_hi,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  output logic         core_start,
  output logic [255:0] core_chain,
  output logic [511:0] core_block,
  input  logic         core_done,
  input  logic [255:0] core_hash,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         exhausted,
  output logic         error,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  hash_count
);
  typedef enum logic [3:0] {
    IDLE, MID_ISSUE, MID_WAIT, B2_ISSUE, B2_WAIT, H2_ISSUE, H2_WAIT, CHECK, FINISH, DRAIN
  } state_t;
  state_t state, state_nx;
  logic [95:0] hdr_hi;
  logic [31:0] n_end, nonce, nonce_b2;
  logic [255:0] tgt, midstate, digest2;
  logic [10:0] cnt;
  logic in_issue, in_wait, tmo, hit, last;
  assign in_issue = state inside {MID_ISSUE, B2_ISSUE, H2_ISSUE};
  assign in_wait = state inside {MID_WAIT, B2_WAIT, H2_WAIT};
  assign tmo = (in_wait || state == DRAIN) && !core_done && cnt >= 11'(TIMEOUT - 2);
  assign hit = digest2 <= tgt;
  assign last = nonce == n_end;
  assign nonce_b2 = state == CHECK ? nonce + 32'd1 : nonce;
  assign core_start = in_issue;
  assign busy = state != IDLE;
  assign done = state == FINISH;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = nonce_start > nonce_end ? FINISH : MID_ISSUE;
      MID_ISSUE: state_nx = MID_WAIT;
      B2_ISSUE:  state_nx = B2_WAIT;
      H2_ISSUE:  state_nx = H2_WAIT;
      MID_WAIT:  state_nx = core_done ? B2_ISSUE : tmo ? FINISH : MID_WAIT;
      B2_WAIT:   state_nx = core_done ? H2_ISSUE : tmo ? FINISH : B2_WAIT;
      H2_WAIT:   state_nx = core_done ? CHECK : tmo ? FINISH : H2_WAIT;
      CHECK:     state_nx = (hit || last) ? FINISH : B2_ISSUE;
      FINISH:    state_nx = IDLE;
      DRAIN:     state_nx = core_done ? IDLE : tmo ? FINISH : DRAIN;
      default:   state_nx = IDLE;
    endcase
    if (abort && state != DRAIN) state_nx = (in_wait && !core_done) ? DRAIN : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_hi <= '0;
      n_end <= '0;
      nonce <= '0;
      tgt <= '0;
      midstate <= '0;
      digest2 <= '0;
      cnt <= '0;
      core_chain <= IV;
      core_block <= '0;
      found <= 1'b0;
      exhausted <= 1'b0;
      error <= 1'b0;
      found_nonce <= '0;
      found_hash <= '0;
      hash_count <= '0;
    end else begin
      cnt <= in_issue ? '0 : cnt + 11'd1;
      if (state == IDLE && state_nx != IDLE) begin
        hdr_hi <= header_hi;
        n_end <= nonce_end;
        tgt <= target;
        nonce <= nonce_start;
        found <= 1'b0;
        exhausted <= nonce_start > nonce_end;
        error <= 1'b0;
        found_nonce <= '0;
        found_hash <= '0;
        hash_count <= '0;
        core_chain <= IV;
        core_block <= header_lo;
      end
      if (state == MID_WAIT && state_nx == B2_ISSUE) begin
        midstate <= core_hash;
        core_chain <= core_hash;
        core_block <= {hdr_hi, nonce_b2, 32'h80000000, 288'b0, 64'd640};
      end
      if (state == B2_WAIT && state_nx == H2_ISSUE) begin
        core_chain <= IV;
        core_block <= {core_hash, 32'h80000000, 160'b0, 64'd256};
      end
      if (state == H2_WAIT && state_nx == CHECK) digest2 <= core_hash;
      if (state == CHECK && state_nx != IDLE) begin
        hash_count <= hash_count + {31'b0, ~&hash_count};
        if (hit) begin
          found <= 1'b1;
          found_nonce <= nonce;
          found_hash <= digest2;
        end else if (last) exhausted <= 1'b1;
        else begin
          nonce <= nonce_b2;
          core_chain <= midstate;
          core_block <= {hdr_hi, nonce_b2, 32'h80000000, 288'b0, 64'd640};
        end
      end
      if (tmo && state_nx == FINISH) error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_upcoin_nonce_scheduler.sv
// tb_upcoin_nonce_scheduler: directed checks of the nonce scheduler against an XOR-folding mock compression core
module tb_upcoin_nonce_scheduler;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [511:0] header_lo = '0;
  logic [95:0] header_hi = '0;
  logic [31:0] nonce_start = '0, nonce_end = '0;
  logic [255:0] target = '0;
  logic core_start, core_done = 1'b0;
  logic [255:0] core_chain, core_hash = '0;
  logic [511:0] core_block;
  logic busy, done, found, exhausted, error;
  logic [31:0] found_nonce, hash_count;
  logic [255:0] found_hash;
  int n_vec = 0, n_bad = 0;
  int cyc = 0, n_iss = 0, n_done = 0, iss_cyc = 0, done_cyc = 0;
  int b_iss = 0, b_done = 0, s_cyc = 0, lat = 3, pend = 0;
  bit hang = 1'b0;
  logic [511:0] blk_log [256];
  logic [255:0] lc = '0;
  logic [511:0] lb = '0;
  logic [511:0] hl1, hl2;
  logic [95:0] hh1, hh2;
  logic [255:0] tg2;
  upcoin_nonce_scheduler dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .header_lo(header_lo), .header_hi(header_hi), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .target(target), .core_start(core_start), .core_chain(core_chain), .core_block(core_block),
    .core_done(core_done), .core_hash(core_hash), .busy(busy), .done(done), .found(found),
    .exhausted(exhausted), .error(error), .found_nonce(found_nonce), .found_hash(found_hash),
    .hash_count(hash_count)
  );
  always #5 clk = ~clk;
  function automatic logic [255:0] mk(input logic [255:0] c, input logic [511:0] b);
    return c ^ b[511:256] ^ b[255:0];
  endfunction
  function automatic logic [255:0] exp_d2(input logic [511:0] hl, input logic [95:0] hh, input logic [31:0] n);
    logic [255:0] m, d1;
    m = mk(IV, hl);
    d1 = mk(m, {hh, n, 32'h80000000, 288'b0, 64'd640});
    return mk(IV, {d1, 32'h80000000, 160'b0, 64'd256});
  endfunction
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1 && !hang) begin
        core_done <= 1'b1;
        core_hash <= mk(lc, lb);
      end
    end
    if (core_start) begin
      lc <= core_chain;
      lb <= core_block;
      pend <= lat;
    end
  end
  always @(posedge clk) begin
    if (core_start) begin
      blk_log[8'(n_iss)] = core_block;
      iss_cyc = cyc;
      n_iss++;
    end
    if (done) begin
      done_cyc = cyc;
      n_done++;
    end
    cyc++;
  end
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic kick(input logic [511:0] hl, input logic [95:0] hh, input logic [31:0] ns,
                      input logic [31:0] ne, input logic [255:0] tg);
    header_lo = hl;
    header_hi = hh;
    nonce_start = ns;
    nonce_end = ne;
    target = tg;
    b_iss = n_iss;
    b_done = n_done;
    s_cyc = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic go(input logic [511:0] hl, input logic [95:0] hh, input logic [31:0] ns,
                    input logic [31:0] ne, input logic [255:0] tg, input int budget);
    kick(hl, hh, ns, ne, tg);
    for (int i = 0; i < budget && n_done == b_done; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int mids;
    hl1 = {8{64'h0123456789ABCDEF}};
    hh1 = 96'hDEADBEEF_CAFEF00D_12345678;
    hl2 = {64'h0100000000000000, 192'h0, 96'h0, 32'hFFFFFFFF, 128'h0};
    hh2 = 96'h4b1e5e4a_29ab5f49_ffff001d;
    repeat (2) @(negedge clk);
    chk("rst_flags", 512'({busy, done, found, exhausted, error, core_start}), 512'(0));
    chk("rst_chain", 512'(core_chain), 512'(IV));
    chk("rst_block", core_block, 512'(0));
    chk("rst_regs", 512'({found_nonce, hash_count, found_hash}), 512'(0));
    reset_n = 1'b1;
    @(negedge clk);
    go(hl1, hh1, 32'd5, 32'd5, '1, 100);
    chk("easy_iss", 512'(n_iss - b_iss), 512'(3));
    chk("easy_found", 512'(found), 512'(1));
    chk("easy_nonce", 512'(found_nonce), 512'(5));
    chk("easy_count", 512'(hash_count), 512'(1));
    chk("easy_done", 512'(n_done - b_done), 512'(1));
    chk("easy_b2blk", blk_log[8'(b_iss + 1)], {hh1, 32'd5, 32'h80000000, 288'b0, 64'd640});
    chk("easy_h2tail", 512'(blk_log[8'(b_iss + 2)][63:0]), 512'(64'h100));
    chk("easy_hash", 512'(found_hash), 512'(exp_d2(hl1, hh1, 32'd5)));
    chk("easy_idle", 512'(busy), 512'(0));
    tg2 = exp_d2(hl2, hh2, 32'h7C2BAC1D);
    go(hl2, hh2, 32'h7C2BAC1A, 32'h7C2BAC1D, tg2, 300);
    chk("kv_found", 512'(found), 512'(1));
    chk("kv_nonce", 512'(found_nonce), 512'(32'h7C2BAC1D));
    chk("kv_count", 512'(hash_count), 512'(4));
    chk("kv_hash", 512'(found_hash), 512'(tg2));
    chk("kv_iss", 512'(n_iss - b_iss), 512'(9));
    mids = 0;
    for (int i = 0; i < 9; i++) if (blk_log[8'(b_iss + i)] == hl2) mids++;
    chk("kv_mid_once", 512'(mids), 512'(1));
    go(hl1, hh1, 32'd10, 32'd12, '0, 300);
    chk("exh_iss", 512'(n_iss - b_iss), 512'(7));
    chk("exh_flags", 512'({found, exhausted}), 512'(2'b01));
    chk("exh_count", 512'(hash_count), 512'(3));
    chk("exh_done", 512'(n_done - b_done), 512'(1));
    go(hl1, hh1, '1, '1, '0, 100);
    repeat (20) @(negedge clk);
    chk("top_iss", 512'(n_iss - b_iss), 512'(3));
    chk("top_flags", 512'({busy, found, exhausted}), 512'(3'b001));
    chk("top_count", 512'(hash_count), 512'(1));
    chk("top_b2nonce", 512'(blk_log[8'(b_iss + 1)][415:384]), 512'(32'hFFFFFFFF));
    go(hl1, hh1, 32'd9, 32'd3, '1, 10);
    chk("inv_iss", 512'(n_iss - b_iss), 512'(0));
    chk("inv_flags", 512'({found, exhausted, error}), 512'(3'b010));
    chk("inv_lat", 512'(done_cyc - s_cyc <= 2), 512'(1));
    lat = 20;
    kick(hl1, hh1, 32'd1, 32'd1, '1);
    for (int i = 0; i < 100 && n_iss - b_iss < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_drain", 512'(busy), 512'(1));
    repeat (5) @(negedge clk);
    chk("abort_held", 512'(busy), 512'(1));
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("abort_idle", 512'(busy), 512'(0));
    chk("abort_nodone", 512'(n_done - b_done), 512'(0));
    chk("abort_iss", 512'(n_iss - b_iss), 512'(2));
    chk("abort_flags", 512'({found, exhausted, error}), 512'(0));
    lat = 3;
    go(hl1, hh1, 32'd7, 32'd7, '1, 100);
    chk("after_abort", 512'({found, found_nonce}), 512'({1'b1, 32'd7}));
    hang = 1'b1;
    go(hl1, hh1, 32'd0, 32'd0, '1, 1100);
    chk("tmo_err", 512'(error), 512'(1));
    chk("tmo_idle", 512'(busy), 512'(0));
    chk("tmo_done", 512'(n_done - b_done), 512'(1));
    chk("tmo_iss", 512'(n_iss - b_iss), 512'(1));
    chk("tmo_lat", 512'(done_cyc - iss_cyc), 512'(1023));
    hang = 1'b0;
    kick(hl1, hh1, 32'd0, 32'd5, '0);
    for (int i = 0; i < 200 && hash_count < 2; i++) @(negedge clk);
    chk("mid_run_cnt", 512'(hash_count >= 2), 512'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_flags", 512'({busy, done, found, exhausted, error, core_start}), 512'(0));
    chk("arst_chain", 512'(core_chain), 512'(IV));
    chk("arst_block", core_block, 512'(0));
    chk("arst_regs", 512'({found_nonce, hash_count, found_hash}), 512'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
